ps2_rx_port: RTL and testbench



---
 rtl/ps2_rx_port_pkg.sv | 22 ++
 rtl/ps2_rx_port_byte_fifo.sv | 62 ++++++
 rtl/ps2_rx_port.sv | 159 +++++++++++++++
 tb/tb_ps2_rx_port.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_port_pkg.sv
// Shared PS/2 receiver definitions: FSM encodings, frame constants, status word layout.
// Used by ps2_rx_port; the optional parity check is selected with PS2_PARITY_CHECK_EN.
package ps2_rx_port_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    localparam int DATA_BITS  = 8;
    localparam int DOUT_VALID = 15;
    localparam int DOUT_OVF   = 14;
    localparam int DOUT_FERR  = 13;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_port_byte_fifo.sv
// Generic synchronous FIFO with push/pop/full/empty and a zero-latency head output.
// Protocol-agnostic so it can be reused behind other serial receivers.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign head_o  = empty_o ? '0 : mem[rd_ptr_q];

    // A pop frees the slot being written, so push-while-full succeeds when popping too.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ps2_rx_port.sv
// Memory-mapped PS/2 keyboard receiver: synchronizes and filters the pins, deframes bytes into a FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity; otherwise the parity bit is ignored.
module ps2_rx_port
    import ps2_rx_port_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic        CLK_50MHZ,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        overflow,
    output logic        frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            clk_sync_q, data_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  filt_clk_q, filt_clk_d;
    logic                  fall, ps2_bit;

    ps2_state_t            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  parity_q, parity_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_err_q, frame_err_d;
    logic                  push, ferr_set, ovf_set, frame_ok;
    logic                  fifo_full, fifo_empty;
    logic [7:0]            head_byte;

    assign ps2_bit = data_sync_q[1];

    // The filtered clock only moves once FILTER_LEN identical samples agree; otherwise it holds.
    always_comb begin
        filt_clk_d = filt_clk_q;
        if (filt_q == '0)      filt_clk_d = 1'b0;
        else if (filt_q == '1) filt_clk_d = 1'b1;
    end

    assign fall = filt_clk_q & ~filt_clk_d;

    always_ff @(posedge CLK_50MHZ or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= '1;
            filt_clk_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
            filt_clk_q  <= filt_clk_d;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = ps2_bit & odd_parity_ok(shreg_q, parity_q);
`else
    assign frame_ok = ps2_bit;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!ps2_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {ps2_bit, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = ps2_bit;
                    state_d  = ST_STOP;
                end
                default: begin
                    push     = frame_ok;
                    ferr_set = ~frame_ok;
                    state_d  = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
            state_d  = ST_IDLE;
            ferr_set = 1'b1;
        end
        tmo_d = (fall || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
    end

    // Error sets win over the read-side clear in the same cycle.
    assign ovf_set     = push & fifo_full & ~rd_en;
    assign overflow_d  = ovf_set | (overflow_q & ~rd_en);
    assign frame_err_d = ferr_set | (frame_err_q & ~rd_en);

    always_ff @(posedge CLK_50MHZ or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    byte_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk_i       (CLK_50MHZ),
        .rst_ni      (reset),
        .push_i      (push),
        .push_data_i (shreg_q),
        .pop_i       (rd_en),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head_byte)
    );

    assign data_valid = ~fifo_empty;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

    always_comb begin
        data_out             = '0;
        data_out[DOUT_VALID] = data_valid;
        data_out[DOUT_OVF]   = overflow_q;
        data_out[DOUT_FERR]  = frame_err_q;
        data_out[7:0]        = head_byte;
    end

endmodule

// File: tb/tb_ps2_rx_port.sv
// Self-checking bench for ps2_rx_port: constant vector table, hand-written corner sequences,
// and random frames/reads compared against a frame-level queue model.
module tb_ps2_rx_port;

    logic        clk = 1'b0;
    logic        reset, ps2_clk, ps2_data, rd_en;
    logic [15:0] data_out;
    logic        data_valid, overflow, frame_err;

    always #10 clk = ~clk;

    ps2_rx_port dut (
        .CLK_50MHZ  (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif
    localparam int HALF  = 15;
    localparam int GAP   = 30;
    localparam int DEPTH = 4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q_m[$];
    bit         ovf_m, ferr_m;

    typedef struct {
        logic [7:0]  b;
        logic        bad_par;
        logic        stop;
        logic [15:0] exp_rx;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vt[7];

    function automatic logic [15:0] model_word();
        logic [7:0] h;
        h = (q_m.size() != 0) ? q_m[0] : 8'h00;
        return {(q_m.size() != 0), ovf_m, ferr_m, 5'b0, h};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        logic par;
        logic ok;
        par = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
        tick(GAP);
        ok = stop && !(PCHK && bad_par);
        if (ok) begin
            if (q_m.size() == DEPTH) ovf_m = 1'b1;
            else q_m.push_back(b);
        end else begin
            ferr_m = 1'b1;
        end
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (q_m.size() != 0) void'(q_m.pop_front());
        ovf_m  = 1'b0;
        ferr_m = 1'b0;
    endtask

    initial begin
        logic [15:0] ovf_exp[4];
        vt[0] = '{8'h1C, 1'b0, 1'b1, 16'h801C, 16'h0000};
        vt[1] = '{8'hF0, 1'b0, 1'b1, 16'h80F0, 16'h0000};
        vt[2] = '{8'h00, 1'b0, 1'b1, 16'h8000, 16'h0000};
        vt[3] = '{8'hFF, 1'b0, 1'b1, 16'h80FF, 16'h0000};
        vt[4] = '{8'h1C, 1'b1, 1'b1, (PCHK ? 16'h2000 : 16'h801C), 16'h0000};
        vt[5] = '{8'h29, 1'b0, 1'b0, 16'h2000, 16'h0000};
        vt[6] = '{8'hA5, 1'b0, 1'b1, 16'h80A5, 16'h0000};
        ovf_exp[0] = 16'hC001; ovf_exp[1] = 16'h8002;
        ovf_exp[2] = 16'h8003; ovf_exp[3] = 16'h8004;

        reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        tick(3);
        check("reset_dout", data_out, 16'h0000);
        check("reset_flags", {13'b0, data_valid, overflow, frame_err}, 16'h0000);
        reset = 1'b1;
        tick(5);

        for (int i = 0; i < 7; i++) begin
            send_frame(vt[i].b, vt[i].bad_par, vt[i].stop);
            check($sformatf("tbl%0d_rx", i), data_out, vt[i].exp_rx);
            do_read();
            check($sformatf("tbl%0d_rd", i), data_out, vt[i].exp_rd);
        end

        // Back-to-back frames keep arrival order.
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("b2b_first", data_out, 16'h80F0);
        do_read();
        check("b2b_second", data_out, 16'h801C);
        do_read();
        check("b2b_empty", data_out, 16'h0000);

        // Five bytes into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
        check("ovf_flag", {15'b0, overflow}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_rd%0d", i), data_out, ovf_exp[i]);
            do_read();
        end
        check("ovf_drained", data_out, 16'h0000);
        do_read();
        check("rd_when_empty", data_out, 16'h0000);

        // Partial frame followed by a long idle clock.
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tick(45000);
        check("tmo_pending", data_out, 16'h0000);
        tick(5200);
        ferr_m = 1'b1;
        check("tmo_ferr", data_out, 16'h2000);
        send_frame(8'h29, 1'b0, 1'b1);
        check("tmo_recover", data_out, 16'hA029);
        check("tmo_model", data_out, model_word());
        do_read();
        check("tmo_read", data_out, 16'h0000);

        // Reset in the middle of a frame with a byte already buffered.
        send_frame(8'h33, 1'b0, 1'b1);
        check("rst_pre", data_out, 16'h8033);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        reset = 1'b0;
        #1;
        check("rst_mid_dout", data_out, 16'h0000);
        check("rst_mid_flags", {13'b0, data_valid, overflow, frame_err}, 16'h0000);
        q_m.delete(); ovf_m = 1'b0; ferr_m = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(4);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("rst_after", data_out, 16'h805A);
        do_read();

        // Random frames and reads against the queue model.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_read();
                check($sformatf("rnd%0d_rd", i), data_out, model_word());
            end else begin
                send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 7) != 0));
                check($sformatf("rnd%0d_rx", i), data_out, model_word());
            end
            check($sformatf("rnd%0d_valid", i), {15'b0, data_valid}, {15'b0, (q_m.size() != 0)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
